// File: rtl/vram_console_ctrl_pkg.sv
// Shared constants, types and cell packing for the text-console controller.
package vga_console_pkg;

  localparam int unsigned COLS       = 80;
  localparam int unsigned ROWS       = 50;
  localparam int unsigned VRAM_WORDS = COLS * ROWS;
  localparam int unsigned AW         = 12;
  localparam int unsigned DW         = 32;
  localparam int unsigned BEW        = 4;
  localparam int unsigned COLW       = 7;
  localparam int unsigned ROWW       = 6;
  localparam int unsigned CLRW       = 12;

  localparam logic [CLRW-1:0] BLANK_COLOR = 12'hFFF;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_TILDE = 8'h7E;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUT,
    ST_SCR_RD,
    ST_SCR_WR,
    ST_FILL,
    ST_CLR
  } console_state_t;

  // Sequencer-side request for VRAM port A
  typedef struct packed {
    logic [AW-1:0]  addr;
    logic [BEW-1:0] be;
    logic           wren;
    logic [DW-1:0]  data;
  } porta_req_t;

  function automatic logic [DW-1:0] pack_cell(input logic [CLRW-1:0] color,
                                              input logic [6:0]      code);
    return {4'h0, color, 9'h000, code};
  endfunction

endpackage

// File: rtl/vram_console_ctrl_if.sv
// Avalon-MM slave bus carrying host accesses into VRAM port A.
interface vram_console_ctrl_if
  import vga_console_pkg::*;
;
  logic [AW-1:0]  av_address;
  logic [BEW-1:0] av_byteenable;
  logic           av_write;
  logic           av_read;
  logic [DW-1:0]  av_writedata;
  logic [DW-1:0]  av_readdata;

  modport master (
    output av_address, av_byteenable, av_write, av_read, av_writedata,
    input  av_readdata
  );

  modport slave (
    input  av_address, av_byteenable, av_write, av_read, av_writedata,
    output av_readdata
  );
endinterface

// File: rtl/vram_porta_arb.sv
// Avalon-priority port A mux with capture of sequencer read data that
// returns while Avalon owns the port.
module vram_porta_arb
  import vga_console_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  vram_console_ctrl_if.slave av,
  input  porta_req_t     seq_req,
  input  logic           seq_rd,
  input  logic [DW-1:0]  vram_q,
  output logic [AW-1:0]  vram_address,
  output logic [BEW-1:0] vram_byteena,
  output logic           vram_wren,
  output logic [DW-1:0]  vram_data,
  output logic           grant_c,
  output logic [DW-1:0]  rdata_c
);

  logic          rd_pend;
  logic [DW-1:0] cap_word;

  assign grant_c        = !(av.av_read || av.av_write);
  assign av.av_readdata = vram_q;

  always_comb begin
    if (grant_c) begin
      vram_address = seq_req.addr;
      vram_byteena = seq_req.be;
      vram_wren    = seq_req.wren;
      vram_data    = seq_req.data;
    end else begin
      vram_address = av.av_address;
      vram_byteena = av.av_byteenable;
      vram_wren    = av.av_write;
      vram_data    = av.av_writedata;
    end
  end

  // Read data is valid one cycle after a granted read, whoever owns the port then
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend  <= 1'b0;
      cap_word <= '0;
    end else begin
      rd_pend <= grant_c && seq_rd;
      if (rd_pend) cap_word <= vram_q;
    end
  end

  assign rdata_c = rd_pend ? vram_q : cap_word;

endmodule

// File: rtl/vram_console_ctrl.sv
// Character-console sequencer: cursor tracking, wrap, scroll-by-copy and
// clear, sharing VRAM port A with an Avalon slave that always wins.
module vram_console_ctrl
  import vga_console_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ch_valid,
  input  logic [7:0]      ch_data,
  input  logic [CLRW-1:0] ch_color,
  output logic            ch_ready,
  input  logic            cmd_clear,
  output logic            busy,
  output logic [COLW-1:0] cursor_col,
  output logic [ROWW-1:0] cursor_row,
  vram_console_ctrl_if.slave av,
  output logic [AW-1:0]   vram_address,
  output logic [BEW-1:0]  vram_byteena,
  output logic            vram_wren,
  output logic [DW-1:0]   vram_data,
  input  logic [DW-1:0]   vram_q
);

  console_state_t  state, state_n;
  logic [COLW-1:0] col, col_n;
  logic [ROWW-1:0] row, row_n;
  logic [AW-1:0]   src, src_n;
  logic [AW-1:0]   dst, dst_n;
  logic [7:0]      code, code_n;
  logic [CLRW-1:0] color, color_n;
  logic            clr_pend, clr_pend_n;

  porta_req_t      req;
  logic            seq_rd;
  logic            grant_c;
  logic [DW-1:0]   rdata_c;
  logic            nl;
  logic            printable;
  logic [AW-1:0]   cur_addr;

  assign printable = (code >= CH_SP) && (code <= CH_TILDE);
  assign cur_addr  = AW'(row) * AW'(COLS) + AW'(col);

  vram_porta_arb u_arb (
    .clk          (clk),
    .reset_n      (reset_n),
    .av           (av),
    .seq_req      (req),
    .seq_rd       (seq_rd),
    .vram_q       (vram_q),
    .vram_address (vram_address),
    .vram_byteena (vram_byteena),
    .vram_wren    (vram_wren),
    .vram_data    (vram_data),
    .grant_c      (grant_c),
    .rdata_c      (rdata_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      col      <= '0;
      row      <= '0;
      src      <= '0;
      dst      <= '0;
      code     <= '0;
      color    <= '0;
      clr_pend <= 1'b0;
    end else begin
      state    <= state_n;
      col      <= col_n;
      row      <= row_n;
      src      <= src_n;
      dst      <= dst_n;
      code     <= code_n;
      color    <= color_n;
      clr_pend <= clr_pend_n;
    end
  end

  // Next-state logic; non-idle states advance only on cycles the port is granted
  always_comb begin
    state_n    = state;
    col_n      = col;
    row_n      = row;
    src_n      = src;
    dst_n      = dst;
    code_n     = code;
    color_n    = color;
    clr_pend_n = clr_pend || cmd_clear;
    ch_ready   = 1'b0;
    seq_rd     = 1'b0;
    nl         = 1'b0;
    req        = '0;
    req.be     = '1;

    case (state)
      ST_IDLE: begin
        if (clr_pend) begin
          state_n    = ST_CLR;
          dst_n      = '0;
          col_n      = '0;
          row_n      = '0;
          clr_pend_n = cmd_clear;
        end else begin
          ch_ready = !cmd_clear;
          if (ch_valid && !cmd_clear) begin
            code_n  = ch_data;
            color_n = ch_color;
            state_n = ST_PUT;
          end
        end
      end

      ST_PUT: begin
        if (printable) begin
          req.wren = 1'b1;
          req.addr = cur_addr;
          req.data = pack_cell(color, code[6:0]);
        end
        if (grant_c) begin
          state_n = ST_IDLE;
          if (printable) begin
            if (col == COLW'(COLS - 1)) nl = 1'b1;
            else                        col_n = col + COLW'(1);
          end else if (code == CH_CR) begin
            col_n = '0;
          end else if (code == CH_LF) begin
            nl = 1'b1;
          end else if (code == CH_BS && col != '0) begin
            col_n = col - COLW'(1);
          end
          if (nl) begin
            col_n = '0;
            if (row == ROWW'(ROWS - 1)) begin
              state_n = ST_SCR_RD;
              src_n   = AW'(COLS);
              dst_n   = '0;
            end else begin
              row_n = row + ROWW'(1);
            end
          end
        end
      end

      ST_SCR_RD: begin
        req.addr = src;
        seq_rd   = 1'b1;
        if (grant_c) state_n = ST_SCR_WR;
      end

      ST_SCR_WR: begin
        req.addr = dst;
        req.wren = 1'b1;
        req.data = rdata_c;
        if (grant_c) begin
          if (src == AW'(VRAM_WORDS - 1)) begin
            state_n = ST_FILL;
            dst_n   = AW'(VRAM_WORDS - COLS);
          end else begin
            state_n = ST_SCR_RD;
            src_n   = src + AW'(1);
            dst_n   = dst + AW'(1);
          end
        end
      end

      ST_FILL, ST_CLR: begin
        req.addr = dst;
        req.wren = 1'b1;
        req.data = pack_cell(BLANK_COLOR, CH_SP[6:0]);
        if (grant_c) begin
          if (dst == AW'(VRAM_WORDS - 1)) state_n = ST_IDLE;
          else                            dst_n   = dst + AW'(1);
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  assign busy       = (state != ST_IDLE) || clr_pend;
  assign cursor_col = col;
  assign cursor_row = row;

endmodule
